// File: rtl/park_pkg.sv
// Shared types and constants for the parking-space allocator.
package park_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } park_state_e;

  localparam int unsigned N_LANES          = 2;
  localparam int unsigned DEFAULT_N_SPACES = 8;

endpackage

// File: rtl/park_first_free.sv
// Lowest-index priority encoder: reports the first set bit of free and whether any bit is set.
module park_first_free
  import park_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N_SPACES
) (
  input  logic [N-1:0]         free,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (free[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_space_allocator.sv
// Two-lane round-robin parking-space allocator with one outstanding reservation.
// Optional reservation expiry is built when PARK_TIMEOUT_EN is defined.
module park_space_allocator
  import park_pkg::*;
#(
  parameter int unsigned N_SPACES = DEFAULT_N_SPACES,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_LANES-1:0]              req,
  output logic [N_LANES-1:0]              gnt,
  output logic [$clog2(N_SPACES)-1:0]     gnt_space,
  input  logic                            park_ack,
  input  logic                            rel_vld,
  input  logic [$clog2(N_SPACES)-1:0]     rel_space,
  output logic [N_SPACES-1:0]             occupied,
  output logic [N_SPACES-1:0]             reserved,
  output logic [$clog2(N_SPACES+1)-1:0]   count,
  output logic                            full,
  output logic                            timeout
);

  localparam int unsigned IW = $clog2(N_SPACES);
  localparam int unsigned CW = $clog2(N_SPACES + 1);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_WAIT = WAIT;

  if (N_SPACES < 2 || N_SPACES > 32 || TIMEOUT < 1) begin : g_param_check
    $error("park_space_allocator: N_SPACES must be 2..32 and TIMEOUT at least 1");
  end

  logic [0:0]          state, state_nx;
  logic                rr_ptr, rr_ptr_nx;
  logic [N_LANES-1:0]  gnt_nx;
  logic [IW-1:0]       gnt_space_nx;
  logic [N_SPACES-1:0] occupied_nx, reserved_nx;
  logic [N_SPACES-1:0] busy, alloc_mask, rel_mask;
  logic [IW-1:0]       free_idx;
  logic                free_found;
  logic                lane;

`ifdef PARK_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             timeout_nx;
`endif

  assign busy  = occupied | reserved;
  assign count = CW'($countones(busy));
  assign full  = (count == CW'(N_SPACES));

  park_first_free #(
    .N (N_SPACES)
  ) u_first_free (
    .free  (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  assign alloc_mask = N_SPACES'(1) << free_idx;
  // Out-of-range indices never match a space.
  assign rel_mask   = (rel_vld && (32'(rel_space) < N_SPACES)) ? (N_SPACES'(1) << rel_space) : '0;

  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    gnt_nx       = '0;
    gnt_space_nx = gnt_space;
    occupied_nx  = occupied & ~rel_mask;
    reserved_nx  = reserved;
    lane         = (req == 2'b11) ? rr_ptr : req[1];
`ifdef PARK_TIMEOUT_EN
    wait_cnt_nx  = wait_cnt;
    timeout_nx   = 1'b0;
`endif
    if (state == S_IDLE) begin
      if ((req != '0) && !full && free_found) begin
        gnt_nx       = lane ? 2'b10 : 2'b01;
        gnt_space_nx = free_idx;
        reserved_nx  = reserved | alloc_mask;
        rr_ptr_nx    = ~lane;
        state_nx     = S_WAIT;
`ifdef PARK_TIMEOUT_EN
        wait_cnt_nx  = '0;
`endif
      end
    end else begin
      // Only one reservation is ever outstanding, so the whole vector moves.
      if (park_ack) begin
        occupied_nx = occupied_nx | reserved;
        reserved_nx = '0;
        state_nx    = S_IDLE;
      end
`ifdef PARK_TIMEOUT_EN
      else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
        reserved_nx = '0;
        timeout_nx  = 1'b1;
        state_nx    = S_IDLE;
      end else begin
        wait_cnt_nx = wait_cnt + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 1'b0;
      gnt       <= '0;
      gnt_space <= '0;
      occupied  <= '0;
      reserved  <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_ptr_nx;
      gnt       <= gnt_nx;
      gnt_space <= gnt_space_nx;
      occupied  <= occupied_nx;
      reserved  <= reserved_nx;
    end
  end

`ifdef PARK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nx;
      timeout  <= timeout_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_park_space_allocator.sv
// Self-checking bench for park_space_allocator: directed table, corner sequences, random vs model.
module tb_park_space_allocator;

  localparam int N   = 8;
  localparam int TMO = 10;
`ifdef PARK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [2:0] gnt_space;
  logic       park_ack;
  logic       rel_vld;
  logic [2:0] rel_space;
  logic [7:0] occupied;
  logic [7:0] reserved;
  logic [3:0] count;
  logic       full;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  park_space_allocator #(.N_SPACES(N), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_space (gnt_space),
    .park_ack  (park_ack),
    .rel_vld   (rel_vld),
    .rel_space (rel_space),
    .occupied  (occupied),
    .reserved  (reserved),
    .count     (count),
    .full      (full),
    .timeout   (timeout)
  );

  // Reference model: per-space status 0 = free, 1 = reserved, 2 = parked.
  int         st [N];
  bit         m_wait;
  int         m_rr;
  int         m_wcnt;
  logic [1:0] m_gnt;
  int         m_space;
  bit         m_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) st[i] = 0;
    m_wait = 0; m_rr = 0; m_wcnt = 0; m_gnt = 2'b00; m_space = 0; m_to = 0;
  endtask

  function automatic int m_used();
    int c = 0;
    for (int i = 0; i < N; i++) if (st[i] != 0) c++;
    return c;
  endfunction

  task automatic model_step(input logic [1:0] r, input logic a, input logic rv, input logic [2:0] rs);
    int freed = -1;
    int pick  = -1;
    int lane;
    if (rv && int'(rs) < N && st[rs] == 2) freed = int'(rs);
    m_gnt = 2'b00;
    m_to  = 0;
    if (!m_wait) begin
      if (r != 2'b00 && m_used() < N) begin
        lane = (r == 2'b11) ? m_rr : (r[1] ? 1 : 0);
        for (int i = 0; i < N; i++) if (st[i] == 0 && pick < 0) pick = i;
        st[pick] = 1;
        m_gnt    = (lane == 1) ? 2'b10 : 2'b01;
        m_space  = pick;
        m_rr     = 1 - lane;
        m_wait   = 1;
        m_wcnt   = 0;
      end
    end else if (a) begin
      for (int i = 0; i < N; i++) if (st[i] == 1) st[i] = 2;
      m_wait = 0;
    end else if (TO_EN) begin
      m_wcnt++;
      if (m_wcnt == TMO) begin
        for (int i = 0; i < N; i++) if (st[i] == 1) st[i] = 0;
        m_to   = 1;
        m_wait = 0;
      end
    end
    if (freed >= 0) st[freed] = 0;
  endtask

  task automatic check_model();
    logic [7:0] eo, er;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      eo[i] = (st[i] == 2);
      er[i] = (st[i] == 1);
      if (st[i] != 0) c++;
    end
    chk("m_occupied", 32'(occupied), 32'(eo));
    chk("m_reserved", 32'(reserved), 32'(er));
    chk("m_gnt", 32'(gnt), 32'(m_gnt));
    if (m_gnt != 2'b00) chk("m_gnt_space", 32'(gnt_space), 32'(m_space));
    chk("m_count", 32'(count), 32'(c));
    chk("m_full", 32'(full), 32'(c == N));
    chk("m_timeout", 32'(timeout), 32'(m_to));
  endtask

  // One clock: inputs applied just after an edge, model stepped, outputs sampled 1 after the next edge.
  task automatic cyc(input logic [1:0] r, input logic a, input logic rv, input logic [2:0] rs);
    req = r; park_ack = a; rel_vld = rv; rel_space = rs;
    model_step(r, a, rv, rs);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0] req;
    logic       ack;
    logic       rv;
    logic [2:0] rs;
    logic [1:0] e_gnt;
    logic [2:0] e_sp;
    logic [7:0] e_occ;
    logic [7:0] e_res;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_to;

    tbl[0]  = '{2'b01, 1'b0, 1'b0, 3'd0, 2'b01, 3'd0, 8'h00, 8'h01, 4'd1};
    tbl[1]  = '{2'b00, 1'b0, 1'b0, 3'd0, 2'b00, 3'd0, 8'h00, 8'h01, 4'd1};
    tbl[2]  = '{2'b00, 1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 8'h01, 8'h00, 4'd1};
    tbl[3]  = '{2'b00, 1'b0, 1'b1, 3'd3, 2'b00, 3'd0, 8'h01, 8'h00, 4'd1};
    tbl[4]  = '{2'b10, 1'b0, 1'b0, 3'd0, 2'b10, 3'd1, 8'h01, 8'h02, 4'd2};
    tbl[5]  = '{2'b00, 1'b0, 1'b1, 3'd1, 2'b00, 3'd1, 8'h01, 8'h02, 4'd2};
    tbl[6]  = '{2'b00, 1'b1, 1'b0, 3'd0, 2'b00, 3'd1, 8'h03, 8'h00, 4'd2};
    tbl[7]  = '{2'b00, 1'b1, 1'b0, 3'd0, 2'b00, 3'd1, 8'h03, 8'h00, 4'd2};
    tbl[8]  = '{2'b00, 1'b0, 1'b1, 3'd0, 2'b00, 3'd1, 8'h02, 8'h00, 4'd1};
    tbl[9]  = '{2'b01, 1'b0, 1'b0, 3'd0, 2'b01, 3'd0, 8'h02, 8'h01, 4'd2};
    tbl[10] = '{2'b00, 1'b1, 1'b0, 3'd0, 2'b00, 3'd0, 8'h03, 8'h00, 4'd2};

    rst_n = 1'b0; req = 2'b00; park_ack = 1'b0; rel_vld = 1'b0; rel_space = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_gnt_space", 32'(gnt_space), 32'd0);
    chk("rst_occupied", 32'(occupied), 32'd0);
    chk("rst_reserved", 32'(reserved), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // Directed table: allocation, parking, invalid releases, ack outside WAIT.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].ack, tbl[i].rv, tbl[i].rs);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      if (tbl[i].e_gnt != 2'b00) chk($sformatf("tbl%0d_space", i), 32'(gnt_space), 32'(tbl[i].e_sp));
      chk($sformatf("tbl%0d_occ", i), 32'(occupied), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_res", i), 32'(reserved), 32'(tbl[i].e_res));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].e_cnt));
    end

    // Fairness: both lanes requesting, ack two cycles after each grant.
    do_reset();
    for (int g = 0; g < 4; g++) begin
      cyc(2'b11, 1'b0, 1'b0, 3'd0);
      chk($sformatf("rr%0d_gnt", g), 32'(gnt), (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_space", g), 32'(gnt_space), 32'(g));
      cyc(2'b11, 1'b0, 1'b0, 3'd0);
      cyc(2'b11, 1'b1, 1'b0, 3'd0);
    end

    // Fill the remaining spaces, then hold a request against a full bank.
    for (int g = 4; g < 8; g++) begin
      cyc(2'b01, 1'b0, 1'b0, 3'd0);
      chk($sformatf("fill%0d_space", g), 32'(gnt_space), 32'(g));
      cyc(2'b00, 1'b0, 1'b0, 3'd0);
      cyc(2'b00, 1'b1, 1'b0, 3'd0);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'd8);
    for (int c = 0; c < 20; c++) begin
      cyc(2'b01, 1'b0, 1'b0, 3'd0);
      chk($sformatf("full_hold%0d_gnt", c), 32'(gnt), 32'd0);
    end
    cyc(2'b01, 1'b0, 1'b1, 3'd5);
    chk("rel5_no_gnt", 32'(gnt), 32'd0);
    chk("rel5_occ", 32'(occupied), 32'hDF);
    chk("rel5_full", 32'(full), 32'd0);
    cyc(2'b01, 1'b0, 1'b0, 3'd0);
    chk("rel5_gnt", 32'(gnt), 32'd1);
    chk("rel5_space", 32'(gnt_space), 32'd5);

    // Asynchronous reset while a reservation is outstanding.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstw_occ", 32'(occupied), 32'd0);
    chk("rstw_res", 32'(reserved), 32'd0);
    chk("rstw_gnt", 32'(gnt), 32'd0);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b01, 1'b0, 1'b0, 3'd0);
    chk("rstw_regnt", 32'(gnt), 32'd1);
    chk("rstw_respace", 32'(gnt_space), 32'd0);
    cyc(2'b00, 1'b1, 1'b0, 3'd0);

    // Reservation left waiting: expires after TMO cycles only when the feature is built.
    cyc(2'b01, 1'b0, 1'b0, 3'd0);
    first_to = -1;
    for (int c = 1; c <= 12; c++) begin
      cyc(2'b00, 1'b0, 1'b0, 3'd0);
      if (timeout === 1'b1 && first_to < 0) first_to = c;
    end
    chk("to_cycle", 32'(first_to), TO_EN ? 32'd10 : 32'hFFFF_FFFF);
    chk("to_reserved", 32'(reserved), TO_EN ? 32'h00 : 32'h02);
    cyc(2'b00, 1'b1, 1'b0, 3'd0);

    // Ack on the expiry cycle parks the car and suppresses the pulse.
    cyc(2'b01, 1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= 9; c++) cyc(2'b00, 1'b0, 1'b0, 3'd0);
    cyc(2'b00, 1'b1, 1'b0, 3'd0);
    chk("ack_exp_timeout", 32'(timeout), 32'd0);
    chk("ack_exp_reserved", 32'(reserved), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
